// File: rtl/iob_reg_arb_pkg.sv
// rtl/iob_reg_arb_pkg.sv - shared defaults and FSM encoding for the register write arbiter
package iob_reg_arb_pkg;

    localparam int          N_REQ_DEF   = 4;
    localparam int          DATA_W_DEF  = 32;
    localparam logic [31:0] RST_VAL_DEF = 32'h0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/iob_reg_arb_if.sv
// rtl/iob_reg_arb_if.sv - requester-side write bus shared by all producers
interface iob_reg_arb_if #(
    parameter int N_REQ  = iob_reg_arb_pkg::N_REQ_DEF,
    parameter int DATA_W = iob_reg_arb_pkg::DATA_W_DEF
);
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_lock_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;

    modport master (
        output req_valid_i, req_lock_i, req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_lock_i, req_data_i,
        output req_ready_o
    );
endinterface

// File: rtl/iob_reg.sv
// rtl/iob_reg.sv - enabled register with asynchronous active-high reset
module iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/iob_rr_prio.sv
// rtl/iob_rr_prio.sv - rotating priority search: first request at or above ptr, wrapping
module iob_rr_prio #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);
    always_comb begin
        logic found;
        int   k;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_i) + i) % N_REQ;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/iob_reg_arb.sv
// rtl/iob_reg_arb.sv - round-robin write arbiter with optional burst lock in front of one iob_reg
module iob_reg_arb
    import iob_reg_arb_pkg::*;
#(
    parameter int                N_REQ   = N_REQ_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VAL_DEF)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cke_i,
    iob_reg_arb_if.slave          req_if,
    output logic [DATA_W-1:0]     data_o,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner_o,
    output logic                  upd_o,
    output logic                  locked_o
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, lock_q, lock_d;
    logic [IDX_W-1:0]  win_idx, sel_idx, nxt_idx;
    logic [N_REQ-1:0]  win_gnt, ready;
    logic              xfer, sel_lock;
    logic [DATA_W-1:0] sel_data;

    iob_rr_prio #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_prio (
        .req_i (req_if.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = sel_lock ? ST_LOCKED : ST_IDLE;
        end
    end

    // Reset gates the grant so no transfer can complete while it is asserted.
    always_comb begin
        ready    = '0;
        locked_o = (state_q == ST_LOCKED);
        if (cke_i && !arst_i) begin
            if (state_q == ST_LOCKED) begin
                ready[lock_q] = req_if.req_valid_i[lock_q];
            end else begin
                ready = win_gnt;
            end
        end
    end

    assign req_if.req_ready_o = ready;

    assign xfer     = |(req_if.req_valid_i & ready);
    assign sel_idx  = (state_q == ST_LOCKED) ? lock_q : win_idx;
    assign sel_data = req_if.req_data_i[int'(sel_idx)*DATA_W +: DATA_W];
    assign sel_lock = req_if.req_lock_i[sel_idx];
    assign nxt_idx  = (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + IDX_W'(1);
    assign ptr_d    = (xfer && !sel_lock) ? nxt_idx : ptr_q;
    assign lock_d   = (xfer && sel_lock) ? sel_idx : lock_q;

    iob_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_data (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i & xfer),
        .data_i(sel_data), .data_o(data_o)
    );

    iob_reg #(.DATA_W(IDX_W), .RST_VAL('0)) u_owner (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i & xfer),
        .data_i(sel_idx), .data_o(owner_o)
    );

    iob_reg #(.DATA_W(IDX_W), .RST_VAL('0)) u_ptr (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .data_i(ptr_d), .data_o(ptr_q)
    );

    iob_reg #(.DATA_W(IDX_W), .RST_VAL('0)) u_lock (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .data_i(lock_d), .data_o(lock_q)
    );

    iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_upd (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .data_i(xfer), .data_o(upd_o)
    );
endmodule

// File: tb/tb_iob_reg_arb.sv
// tb/tb_iob_reg_arb.sv - directed self-checking bench for iob_reg_arb
module tb_iob_reg_arb;
    localparam int          N  = 4;
    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         arst;
    logic         cke;
    logic [W-1:0] data;
    logic [1:0]   owner;
    logic         upd;
    logic         locked;
    int           checks   = 0;
    int           failures = 0;

    iob_reg_arb_if #(.N_REQ(N), .DATA_W(W)) bus ();

    iob_reg_arb #(.N_REQ(N), .DATA_W(W), .RST_VAL(RV)) dut (
        .clk_i    (clk),
        .arst_i   (arst),
        .cke_i    (cke),
        .req_if   (bus),
        .data_o   (data),
        .owner_o  (owner),
        .upd_o    (upd),
        .locked_o (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        bus.req_data_i[k*W +: W] = v;
    endtask

    task automatic test_reset();
        arst = 1'b0; cke = 1'b1;
        bus.req_valid_i = '0; bus.req_lock_i = '0; bus.req_data_i = '0;
        #2 arst = 1'b1;
        #1;
        checks++; if (data !== RV) begin failures++; $display("FAIL rst_data got=%h exp=%h", data, RV); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL rst_upd got=%b exp=0", upd); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
        bus.req_valid_i = 4'hF;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready_o); end
        tick();
        arst = 1'b0;
        bus.req_valid_i = '0;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < N; k++) set_data(k, 32'h10 + k);
        bus.req_valid_i = 4'hF; bus.req_lock_i = '0;
        for (int c = 0; c < 8; c++) begin
            int e;
            e = c % 4;
            #1;
            checks++; if (bus.req_ready_o !== 4'(1 << e)) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, 4'(1 << e)); end
            tick();
            checks++; if (data !== 32'(32'h10 + e)) begin failures++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, data, 32'h10 + e); end
            checks++; if (owner !== 2'(e)) begin failures++; $display("FAIL rr_owner c=%0d got=%0d exp=%0d", c, owner, e); end
            checks++; if (upd !== 1'b1) begin failures++; $display("FAIL rr_upd c=%0d got=%b exp=1", c, upd); end
        end
        bus.req_valid_i = '0;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL rr_idle_ready got=%b exp=0000", bus.req_ready_o); end
        tick();
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL rr_idle_upd got=%b exp=0", upd); end
        checks++; if (data !== 32'h13) begin failures++; $display("FAIL rr_idle_data got=%h exp=13", data); end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_rdy [3];
        int         exp_idx [3];
        exp_rdy = '{4'b0001, 4'b0100, 4'b0001};
        exp_idx = '{0, 2, 0};
        for (int k = 0; k < N; k++) set_data(k, 32'h20 + k);
        bus.req_valid_i = 4'b0100;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin failures++; $display("FAIL ws_pre_ready got=%b exp=0100", bus.req_ready_o); end
        tick();
        bus.req_valid_i = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready_o !== exp_rdy[c]) begin failures++; $display("FAIL ws_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_rdy[c]); end
            tick();
            checks++; if (data !== 32'(32'h20 + exp_idx[c])) begin failures++; $display("FAIL ws_data c=%0d got=%h exp=%h", c, data, 32'h20 + exp_idx[c]); end
            checks++; if (upd !== 1'b1) begin failures++; $display("FAIL ws_upd c=%0d got=%b exp=1", c, upd); end
        end
    endtask

    task automatic test_lock();
        logic [31:0] d1 [3];
        logic [3:0]  lk [3];
        logic        el [3];
        d1 = '{32'h11, 32'h22, 32'h33};
        lk = '{4'b1011, 4'b1011, 4'b1001};
        el = '{1'b1, 1'b1, 1'b0};
        bus.req_valid_i = 4'hF;
        for (int c = 0; c < 3; c++) begin
            set_data(1, d1[c]);
            bus.req_lock_i = lk[c];
            #1;
            checks++; if (bus.req_ready_o !== 4'b0010) begin failures++; $display("FAIL lk_ready c=%0d got=%b exp=0010", c, bus.req_ready_o); end
            tick();
            checks++; if (data !== d1[c]) begin failures++; $display("FAIL lk_data c=%0d got=%h exp=%h", c, data, d1[c]); end
            checks++; if (owner !== 2'd1) begin failures++; $display("FAIL lk_owner c=%0d got=%0d exp=1", c, owner); end
            checks++; if (locked !== el[c]) begin failures++; $display("FAIL lk_locked c=%0d got=%b exp=%b", c, locked, el[c]); end
        end
        bus.req_valid_i = 4'b1101;
        bus.req_lock_i  = 4'b0100;
        set_data(2, 32'h44);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin failures++; $display("FAIL lk_next_ready got=%b exp=0100", bus.req_ready_o); end
        tick();
        checks++; if (data !== 32'h44) begin failures++; $display("FAIL lk_next_data got=%h exp=44", data); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lk_next_locked got=%b exp=1", locked); end
    endtask

    task automatic test_locked_stall();
        bus.req_valid_i = 4'b1011;
        bus.req_lock_i  = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL st_ready c=%0d got=%b exp=0000", c, bus.req_ready_o); end
            tick();
            checks++; if (data !== 32'h44) begin failures++; $display("FAIL st_data c=%0d got=%h exp=44", c, data); end
            checks++; if (locked !== 1'b1 || owner !== 2'd2) begin failures++; $display("FAIL st_state c=%0d got=%b/%0d exp=1/2", c, locked, owner); end
        end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL st_upd got=%b exp=0", upd); end
        bus.req_valid_i = 4'hF;
        bus.req_lock_i  = 4'b0100;
        set_data(2, 32'h55);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin failures++; $display("FAIL st_resume_ready got=%b exp=0100", bus.req_ready_o); end
        tick();
        checks++; if (data !== 32'h55 || upd !== 1'b1) begin failures++; $display("FAIL st_resume_data got=%h/%b exp=55/1", data, upd); end
    endtask

    task automatic test_cke_reset();
        cke = 1'b0;
        set_data(2, 32'h66);
        bus.req_valid_i = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL ck_ready c=%0d got=%b exp=0000", c, bus.req_ready_o); end
            tick();
            checks++; if (data !== 32'h55 || owner !== 2'd2) begin failures++; $display("FAIL ck_data c=%0d got=%h/%0d exp=55/2", c, data, owner); end
            checks++; if (upd !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL ck_flags c=%0d got=%b/%b exp=1/1", c, upd, locked); end
        end
        cke = 1'b1;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin failures++; $display("FAIL ck_resume_ready got=%b exp=0100", bus.req_ready_o); end
        #1 arst = 1'b1;
        #1;
        checks++; if (data !== RV || owner !== 2'd0) begin failures++; $display("FAIL ar_data got=%h/%0d exp=%h/0", data, owner, RV); end
        checks++; if (upd !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL ar_flags got=%b/%b exp=0/0", upd, locked); end
        checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL ar_ready got=%b exp=0000", bus.req_ready_o); end
        tick();
        checks++; if (data !== RV) begin failures++; $display("FAIL ar_hold_data got=%h exp=%h", data, RV); end
        arst = 1'b0;
        bus.req_valid_i = 4'b1010;
        bus.req_lock_i  = '0;
        set_data(1, 32'h77);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0010) begin failures++; $display("FAIL ar_first_ready got=%b exp=0010", bus.req_ready_o); end
        tick();
        checks++; if (data !== 32'h77 || owner !== 2'd1) begin failures++; $display("FAIL ar_first_data got=%h/%0d exp=77/1", data, owner); end
        bus.req_valid_i = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_lock();
        test_locked_stall();
        test_cke_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
